mgt_01_mul_ip: RTL and testbench



---
 rtl/mgt_01_pkg.sv | 13 +
 rtl/mgt_01_mul_core.sv | 31 +++
 rtl/mgt_01_mul_ip.sv | 41 ++++
 tb/tb_mgt_01_mul_ip.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mgt_01_pkg.sv
// mgt_01_pkg: shared data and opcode types for the MicroGT-01 multiplier.
package mgt_01_pkg;
  typedef union packed {
    logic signed [31:0] s;
    logic [31:0] u;
  } data_u;
  typedef enum logic [1:0] {
    MUL_U    = 2'b00,
    MULH_U   = 2'b01,
    MULHSU_U = 2'b10,
    MULHU_U  = 2'b11
  } mul_ops_e;
endpackage

// File: rtl/mgt_01_mul_core.sv
// mgt_01_mul_core: signed 33x33 multiplier; registers four 17x17 partial products, sums them combinationally.
module mgt_01_mul_core (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clk_en_i,
  input  logic signed [32:0] a,
  input  logic signed [32:0] b,
  output logic [63:0] prod
);
  logic signed [16:0] a_hi, a_lo, b_hi, b_lo;
  logic signed [33:0] pp_hh, pp_hl, pp_lh, pp_ll;
  // low halves are unsigned magnitudes; a leading zero keeps them non-negative in signed math
  assign a_hi = a[32:16];
  assign b_hi = b[32:16];
  assign a_lo = {1'b0, a[15:0]};
  assign b_lo = {1'b0, b[15:0]};
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      pp_hh <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
      pp_ll <= '0;
    end else if (clk_en_i) begin
      pp_hh <= 34'(a_hi) * 34'(b_hi);
      pp_hl <= 34'(a_hi) * 34'(b_lo);
      pp_lh <= 34'(a_lo) * 34'(b_hi);
      pp_ll <= 34'(a_lo) * 34'(b_lo);
    end
  // only bits [63:0] are ever selected, so the sum wraps at 64 bits
  assign prod = (64'(pp_hh) << 32) + ((64'(pp_hl) + 64'(pp_lh)) << 16) + 64'(pp_ll);
endmodule

// File: rtl/mgt_01_mul_ip.sv
// mgt_01_mul_ip: three-stage RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with pipeline-wide clock enable.
module mgt_01_mul_ip
  import mgt_01_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clk_en_i,
  input  data_u op_A_i,
  input  data_u op_B_i,
  input  mul_ops_e ops_i,
  output data_u result_o
);
  logic signed [32:0] a1, b1;
  mul_ops_e op1, op2;
  logic [63:0] prod;
  logic sa, sb;
  assign sa = (ops_i == MULH_U || ops_i == MULHSU_U) & op_A_i.u[31];
  assign sb = (ops_i == MULH_U) & op_B_i.u[31];
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      a1 <= '0;
      b1 <= '0;
      op1 <= MUL_U;
      op2 <= MUL_U;
      result_o <= '0;
    end else if (clk_en_i) begin
      a1 <= {sa, op_A_i.u};
      b1 <= {sb, op_B_i.u};
      op1 <= ops_i;
      op2 <= op1;
      result_o.u <= (op2 == MUL_U) ? prod[31:0] : prod[63:32];
    end
  mgt_01_mul_core u_core (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .clk_en_i(clk_en_i),
    .a(a1),
    .b(b1),
    .prod(prod)
  );
endmodule

// File: tb/tb_mgt_01_mul_ip.sv
// tb_mgt_01_mul_ip: scoreboard bench; stimulus queues expected results, a monitor checks each enabled edge.
module tb_mgt_01_mul_ip;
  import mgt_01_pkg::*;
  logic clk = 0, rst_n = 0, en = 0;
  data_u op_a, op_b, result;
  mul_ops_e ops = MUL_U;
  typedef struct {
    logic [31:0] exp;
    int due;
    mul_ops_e op;
  } item_t;
  item_t q[$];
  int edge_cnt = 0, n_cmp = 0, n_err = 0;
  bit idle_zero = 1;
  logic [31:0] last = 0;

  mgt_01_mul_ip dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .clk_en_i(en),
    .op_A_i(op_a),
    .op_B_i(op_b),
    .ops_i(ops),
    .result_o(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, mul_ops_e op);
    longint sa, sb, p;
    sa = (op == MULH_U || op == MULHSU_U) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (op == MULH_U) ? longint'($signed(b)) : longint'({32'b0, b});
    p = sa * sb;
    return (op == MUL_U) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic en_s, rst_s;
    item_t it;
    en_s = en;
    rst_s = rst_n;
    #1;
    if (rst_s && rst_n && en_s) begin
      edge_cnt++;
      if (q.size() != 0 && q[0].due == edge_cnt) begin
        it = q.pop_front();
        idle_zero = 0;
        check(it.op.name(), result.u, it.exp);
      end else if (idle_zero)
        check("idle_zero", result.u, 32'h0);
    end else if (rst_s && rst_n)
      check("stall_hold", result.u, last);
    last = result.u;
  end

  task automatic issue(logic [31:0] a, logic [31:0] b, mul_ops_e op);
    @(negedge clk);
    op_a.u = a;
    op_b.u = b;
    ops = op;
    en = 1;
    q.push_back('{exp: model(a, b, op), due: edge_cnt + 3, op: op});
  endtask

  task automatic issue_rand();
    issue($urandom, ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom, mul_ops_e'($urandom_range(0, 3)));
  endtask

  task automatic stall(int n);
    repeat (n) begin
      @(negedge clk);
      en = 0;
      op_a.u = $urandom;
      op_b.u = $urandom;
      ops = mul_ops_e'($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("async_reset", result.u, 32'h0);
    q.delete();
    idle_zero = 1;
    last = 0;
    @(negedge clk);
    en = 0;
    @(negedge clk);
    check("reset_hold", result.u, 32'h0);
    rst_n = 1;
  endtask

  initial begin
    op_a.u = 0;
    op_b.u = 0;
    #2 check("reset_state", result.u, 32'h0);
    @(negedge clk);
    rst_n = 1;
    issue(9, 32'hFFFFFFF6, MUL_U);
    issue(45, 1, MUL_U);
    issue(91234, 102345, MULH_U);
    issue(91234, 102345, MUL_U);
    issue(-9, -10, MULHU_U);
    issue(-9, -10, MULHSU_U);
    issue(-9, -10, MULH_U);
    issue(32'h80000000, 32'h80000000, MULH_U);
    issue(32'h80000000, 32'h80000000, MULHU_U);
    issue(32'h80000000, 32'h80000000, MULHSU_U);
    issue(32'h80000000, 32'h80000000, MUL_U);
    repeat (100) issue_rand();
    stall(2);
    repeat (50) issue_rand();
    stall(1);
    issue_rand();
    stall(3);
    repeat (20) issue_rand();
    do_reset();
    issue(7, 6, MUL_U);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, MULHU_U);
    repeat (100) issue_rand();
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk);
      en = 1;
      op_a.u = $urandom;
      op_b.u = $urandom;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
